trigger_pulse_scheduler: RTL and testbench

- Receive-side stage of the WR trigger-distribution path. Sits directly downstream of the streamer RX decoder.
- Accepts trigger timestamps (TAI seconds + 125 MHz cycle count) from the remote node and adds a fixed link-compensation delay.
- Queues the resulting targets and drives a fixed-width output pulse when local WR time reaches each target, so the remote trigger is reproduced with a deterministic 20 us delay.

---
 rtl/trigger_pulse_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_trigger_pulse_scheduler.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_pulse_scheduler.sv
// Purpose: reproduces remote WR triggers locally, delayed by a fixed link-compensation offset.
// Latency: target is queued 1 cycle after accept; pulse_o rises 1 cycle after local time equals the target.
// Backpressure: ts_ready_o drops once queued + in-flight targets reach g_fifo_depth; extra timestamps are dropped and flagged.
//
// Ports:
//   clk_ref_i, rst_n_i        : 125 MHz WR reference clock, asynchronous active-low reset
//   enable_i                  : block enable; low flushes queue and adder stage and stops the pulse
//   tm_time_valid_i, tm_tai_i, tm_cycles_i : local WR time (TAI seconds + cycles within the second)
//   ts_valid_i, ts_tai_i, ts_cycles_i, ts_ready_o : incoming remote trigger timestamps (valid/ready)
//   pulse_o                   : reproduced trigger pulse, g_pulse_width cycles wide
//   missed_o                  : 1-cycle strobe, a queued target was already in the past and was dropped
//   overflow_o                : 1-cycle strobe, a timestamp was offered while not ready and was dropped
//   fifo_count_o              : number of targets currently queued
module trigger_pulse_scheduler #(
  parameter int g_fifo_depth   = 16,
  parameter int g_delay_cycles = 2500,
  parameter int g_pulse_width  = 125,
  parameter int g_clk_freq     = 125000000
) (
  input  logic                              clk_ref_i,
  input  logic                              rst_n_i,
  input  logic                              enable_i,
  input  logic                              tm_time_valid_i,
  input  logic [39:0]                       tm_tai_i,
  input  logic [27:0]                       tm_cycles_i,
  input  logic                              ts_valid_i,
  input  logic [39:0]                       ts_tai_i,
  input  logic [27:0]                       ts_cycles_i,
  output logic                              ts_ready_o,
  output logic                              pulse_o,
  output logic                              missed_o,
  output logic                              overflow_o,
  output logic [$clog2(g_fifo_depth+1)-1:0] fifo_count_o
);

  localparam int CW = $clog2(g_fifo_depth + 1);
  localparam int AW = $clog2(g_fifo_depth);
  localparam int PW = $clog2(g_pulse_width + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_FIRE
  } state_t;

  // ---------------------------------------------------------------------------
  // Adder stage: timestamp + fixed delay, carrying into TAI at the second wrap
  // ---------------------------------------------------------------------------
  logic [28:0] w_sum;
  logic        w_wrap;
  logic        w_accept;
  logic [CW:0] w_occ;

  logic        r_add_vld;
  logic [39:0] r_add_tai;
  logic [27:0] r_add_cyc;
  logic        r_overflow;

  // One extra bit so the sum of a full-range cycle field and the delay cannot overflow
  assign w_sum  = {1'b0, ts_cycles_i} + 29'(g_delay_cycles);
  assign w_wrap = (w_sum >= 29'(g_clk_freq));

  // The in-flight adder entry is counted so a push can never land in a full queue
  assign w_occ      = (CW + 1)'(fifo_count_o) + (CW + 1)'(r_add_vld);
  assign ts_ready_o = enable_i && (w_occ < (CW + 1)'(g_fifo_depth));
  assign w_accept   = ts_valid_i && ts_ready_o;

  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_add_vld  <= 1'b0;
      r_add_tai  <= '0;
      r_add_cyc  <= '0;
      r_overflow <= 1'b0;
    end else begin
      // ts_ready_o is low while disabled, so this also flushes the stage
      r_add_vld  <= w_accept;
      r_overflow <= enable_i && ts_valid_i && !ts_ready_o;
      if (w_accept) begin
        if (w_wrap) begin
          r_add_cyc <= 28'(w_sum - 29'(g_clk_freq));
          r_add_tai <= ts_tai_i + 40'd1;
        end else begin
          r_add_cyc <= 28'(w_sum);
          r_add_tai <= ts_tai_i;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Target queue
  // ---------------------------------------------------------------------------
  logic [67:0]   r_mem [g_fifo_depth];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;
  logic          w_match;
  logic [67:0]   w_head;
  logic [67:0]   w_local;

  assign w_push       = r_add_vld && enable_i;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_local      = {tm_tai_i, tm_cycles_i};
  assign fifo_count_o = r_count;

  state_t        r_state;
  logic          r_pulse;
  logic          r_missed;
  logic [PW-1:0] r_pcnt;

  // Head leaves the queue when it is due now or already past; TAI-major unsigned compare
  assign w_match = (w_local == w_head);
  assign w_pop   = enable_i && (r_state == ST_ARMED) && tm_time_valid_i &&
                   (r_count != '0) && (w_local >= w_head);

  always_ff @(posedge clk_ref_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_add_tai, r_add_cyc};
    end
  end

  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (!enable_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_IDLE;
      r_pulse  <= 1'b0;
      r_missed <= 1'b0;
      r_pcnt   <= '0;
    end else if (!enable_i) begin
      r_state  <= ST_IDLE;
      r_pulse  <= 1'b0;
      r_missed <= 1'b0;
      r_pcnt   <= '0;
    end else begin
      // w_pop is only true in ARMED, so a late head is dropped and flagged from there only
      r_missed <= w_pop && !w_match;
      case (r_state)
        ST_IDLE: begin
          if ((r_count != '0) && tm_time_valid_i) r_state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (w_pop && w_match) begin
            r_pulse <= 1'b1;
            r_pcnt  <= PW'(g_pulse_width - 1);
            r_state <= ST_FIRE;
          end else if (!tm_time_valid_i || (r_count == '0)) begin
            r_state <= ST_IDLE;
          end
        end
        ST_FIRE: begin
          // Runs off the clock alone so the width is exact even if WR time drops out
          if (r_pcnt == '0) begin
            r_pulse <= 1'b0;
            r_state <= tm_time_valid_i ? ST_ARMED : ST_IDLE;
          end else begin
            r_pcnt <= r_pcnt - PW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pulse_o    = r_pulse;
  assign missed_o   = r_missed;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_trigger_pulse_scheduler.sv
`timescale 1ns/1ps
module tb_trigger_pulse_scheduler;

  localparam int CLK_FREQ = 125000000;
  localparam int DELAY    = 2500;
  localparam int PWIDTH   = 125;

  logic        clk_ref_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        tm_time_valid_i = 1'b0;
  logic [39:0] tm_tai_i = '0;
  logic [27:0] tm_cycles_i = '0;
  logic        ts_valid_i = 1'b0;
  logic [39:0] ts_tai_i = '0;
  logic [27:0] ts_cycles_i = '0;
  logic        ts_ready_o;
  logic        pulse_o;
  logic        missed_o;
  logic        overflow_o;
  logic [4:0]  fifo_count_o;

  trigger_pulse_scheduler dut (
    .clk_ref_i       (clk_ref_i),
    .rst_n_i         (rst_n_i),
    .enable_i        (enable_i),
    .tm_time_valid_i (tm_time_valid_i),
    .tm_tai_i        (tm_tai_i),
    .tm_cycles_i     (tm_cycles_i),
    .ts_valid_i      (ts_valid_i),
    .ts_tai_i        (ts_tai_i),
    .ts_cycles_i     (ts_cycles_i),
    .ts_ready_o      (ts_ready_o),
    .pulse_o         (pulse_o),
    .missed_o        (missed_o),
    .overflow_o      (overflow_o),
    .fifo_count_o    (fifo_count_o)
  );

  always #4 clk_ref_i = ~clk_ref_i;

  typedef struct {
    logic        fire;
    logic [39:0] tai;
    logic [27:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        time_run = 1'b0;
  logic [39:0] edge_tai = '0;
  logic [27:0] edge_cyc = '0;

  // Advance one clock; remember the local time the DUT saw at that edge, then move time on
  task automatic tick();
    @(posedge clk_ref_i);
    edge_tai = tm_tai_i;
    edge_cyc = tm_cycles_i;
    #1;
    if (time_run) begin
      if (tm_cycles_i == 28'(CLK_FREQ - 1)) begin
        tm_cycles_i = '0;
        tm_tai_i    = tm_tai_i + 40'd1;
      end else begin
        tm_cycles_i = tm_cycles_i + 28'd1;
      end
    end
  endtask

  task automatic set_time(input logic [39:0] tai, input logic [27:0] cyc);
    tm_tai_i    = tai;
    tm_cycles_i = cyc;
  endtask

  function automatic exp_t target_of(input logic [39:0] tai, input logic [27:0] cyc, input logic fire);
    exp_t   e;
    longint c;
    c      = longint'(cyc) + longint'(DELAY);
    e.fire = fire;
    if (c >= longint'(CLK_FREQ)) begin
      e.cyc = 28'(c - longint'(CLK_FREQ));
      e.tai = tai + 40'd1;
    end else begin
      e.cyc = 28'(c);
      e.tai = tai;
    end
    return e;
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    e.fire = 1'bx;
    e.tai  = 'x;
    e.cyc  = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  // Offer one timestamp for one cycle; the expected target is queued only if it will be accepted
  task automatic send(input logic [39:0] tai, input logic [27:0] cyc, input logic fire);
    ts_valid_i  = 1'b1;
    ts_tai_i    = tai;
    ts_cycles_i = cyc;
    if (ts_ready_o === 1'b1) sb.push_back(target_of(tai, cyc, fire));
    tick();
    ts_valid_i = 1'b0;
  endtask

  task automatic wait_rise(input int limit, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (pulse_o === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic measure_high(output int w);
    w = 0;
    while (pulse_o === 1'b1 && w < 400) begin
      w++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n_i  = 1'b0;
    enable_i = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (pulse_o !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b want 0", pulse_o); end
    n_tests++;
    if (missed_o !== 1'b0) begin n_fail++; $display("FAIL reset_missed: got %b want 0", missed_o); end
    n_tests++;
    if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
    n_tests++;
    if (fifo_count_o !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count_o); end
    n_tests++;
    if (ts_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ts_ready_o); end
    rst_n_i  = 1'b1;
    enable_i = 1'b1;
    tick();
    n_tests++;
    if (ts_ready_o !== 1'b1) begin n_fail++; $display("FAIL ready_after_enable: got %b want 1", ts_ready_o); end
  endtask

  task automatic test_single();
    logic seen;
    int   w;
    exp_t e;
    time_run        = 1'b1;
    tm_time_valid_i = 1'b1;
    set_time(40'd5, 28'd0);
    send(40'd5, 28'd1000, 1'b1);
    wait_rise(6000, seen);
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL single_rise: pulse_o never rose, want rise at (5,3500)");
    end else begin
      e = pop_exp();
      n_tests++;
      if (e.fire !== 1'b1 || {edge_tai, edge_cyc} !== {e.tai, e.cyc})
        begin n_fail++; $display("FAIL single_time: rose at (%0d,%0d) want (%0d,%0d)", edge_tai, edge_cyc, e.tai, e.cyc); end
      measure_high(w);
      n_tests++;
      if (w != PWIDTH) begin n_fail++; $display("FAIL single_width: got %0d want %0d", w, PWIDTH); end
    end
    n_tests++;
    if (fifo_count_o !== 5'd0) begin n_fail++; $display("FAIL single_count: got %0d want 0", fifo_count_o); end
  endtask

  task automatic test_wrap();
    logic seen;
    int   highs;
    int   w;
    exp_t e;
    set_time(40'd7, 28'd1000);
    send(40'd7, 28'd124999000, 1'b1);
    highs = 0;
    for (int i = 0; i < 2000 && tm_cycles_i != 28'd1700; i++) begin
      tick();
      if (pulse_o === 1'b1) highs++;
    end
    n_tests++;
    if (highs != 0) begin n_fail++; $display("FAIL wrap_early: pulse high %0d cycles near (7,1500), want 0", highs); end
    set_time(40'd8, 28'd1000);
    wait_rise(1000, seen);
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL wrap_rise: pulse_o never rose, want rise at (8,1500)");
    end else begin
      e = pop_exp();
      n_tests++;
      if (e.fire !== 1'b1 || {edge_tai, edge_cyc} !== {40'd8, 28'd1500} || {e.tai, e.cyc} !== {40'd8, 28'd1500})
        begin n_fail++; $display("FAIL wrap_time: rose at (%0d,%0d) want (8,1500)", edge_tai, edge_cyc); end
      measure_high(w);
      n_tests++;
      if (w != PWIDTH) begin n_fail++; $display("FAIL wrap_width: got %0d want %0d", w, PWIDTH); end
    end
  endtask

  task automatic test_late();
    logic       seen;
    int         highs;
    logic [4:0] maxcnt;
    exp_t       e;
    set_time(40'd10, 28'd0);
    send(40'd9, 28'd0, 1'b0);
    seen   = 1'b0;
    highs  = 0;
    maxcnt = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (fifo_count_o > maxcnt) maxcnt = fifo_count_o;
      if (pulse_o === 1'b1) highs++;
      if (missed_o === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL late_missed: missed_o never seen, want 1");
    end else begin
      e = pop_exp();
      n_tests++;
      if (e.fire !== 1'b0) begin n_fail++; $display("FAIL late_sb: dropped entry fire=%b want 0", e.fire); end
    end
    n_tests++;
    if (maxcnt !== 5'd1) begin n_fail++; $display("FAIL late_peak: count peaked %0d want 1", maxcnt); end
    n_tests++;
    if (fifo_count_o !== 5'd0) begin n_fail++; $display("FAIL late_count: got %0d want 0", fifo_count_o); end
    tick();
    if (pulse_o === 1'b1) highs++;
    n_tests++;
    if (missed_o !== 1'b0) begin n_fail++; $display("FAIL late_strobe: missed_o %b want 0 one cycle later", missed_o); end
    n_tests++;
    if (highs != 0) begin n_fail++; $display("FAIL late_pulse: pulse high %0d cycles want 0", highs); end
  endtask

  task automatic test_full();
    logic seen;
    int   w;
    exp_t e;
    set_time(40'd20, 28'd0);
    for (int i = 0; i < 16; i++) send(40'd20, 28'(1000 + i * 200), 1'b1);
    n_tests++;
    if (ts_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0 after 16 accepts", ts_ready_o); end
    send(40'd20, 28'd0, 1'b1);
    n_tests++;
    if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL full_overflow: got %b want 1", overflow_o); end
    n_tests++;
    if (fifo_count_o !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d want 16", fifo_count_o); end
    tick();
    n_tests++;
    if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL full_overflow_len: got %b want 0", overflow_o); end
    n_tests++;
    if (sb.size() != 16) begin n_fail++; $display("FAIL full_sb: %0d entries accepted want 16", sb.size()); end
    for (int k = 0; k < 16; k++) begin
      wait_rise(4000, seen);
      n_tests++;
      if (!seen) begin
        n_fail++; $display("FAIL full_rise%0d: pulse_o never rose", k);
        break;
      end
      e = pop_exp();
      n_tests++;
      if (e.fire !== 1'b1 || {edge_tai, edge_cyc} !== {e.tai, e.cyc})
        begin n_fail++; $display("FAIL full_time%0d: rose at (%0d,%0d) want (%0d,%0d)", k, edge_tai, edge_cyc, e.tai, e.cyc); end
      if (k == 0) begin
        n_tests++;
        if (ts_ready_o !== 1'b1 || fifo_count_o !== 5'd15)
          begin n_fail++; $display("FAIL full_pop: ready=%b count=%0d want ready=1 count=15", ts_ready_o, fifo_count_o); end
      end
      measure_high(w);
      n_tests++;
      if (w != PWIDTH) begin n_fail++; $display("FAIL full_width%0d: got %0d want %0d", k, w, PWIDTH); end
    end
    n_tests++;
    if (fifo_count_o !== 5'd0) begin n_fail++; $display("FAIL full_drain: got %0d want 0", fifo_count_o); end
  endtask

  task automatic test_time_invalid();
    logic seen;
    int   highs;
    int   w;
    exp_t e;
    tm_time_valid_i = 1'b0;
    set_time(40'd3, 28'd0);
    send(40'd2, 28'd124998000, 1'b0);
    highs = 0;
    for (int i = 0; i < 1000 && tm_cycles_i != 28'd600; i++) begin
      tick();
      if (pulse_o === 1'b1) highs++;
    end
    n_tests++;
    if (fifo_count_o !== 5'd1) begin n_fail++; $display("FAIL inv_retained: count %0d want 1", fifo_count_o); end
    tm_time_valid_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (pulse_o === 1'b1) highs++;
      if (missed_o === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL inv_missed: missed_o never seen, want 1");
    end else begin
      e = pop_exp();
      n_tests++;
      if (e.fire !== 1'b0 || {e.tai, e.cyc} !== {40'd3, 28'd500})
        begin n_fail++; $display("FAIL inv_sb: entry (%0d,%0d) fire=%b want (3,500) fire=0", e.tai, e.cyc, e.fire); end
    end
    n_tests++;
    if (highs != 0) begin n_fail++; $display("FAIL inv_pulse: pulse high %0d cycles want 0", highs); end
    send(40'd2, 28'd124998400, 1'b1);
    wait_rise(1000, seen);
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL inv_rise: pulse_o never rose, want rise at (3,900)");
    end else begin
      e = pop_exp();
      n_tests++;
      if (e.fire !== 1'b1 || {edge_tai, edge_cyc} !== {40'd3, 28'd900})
        begin n_fail++; $display("FAIL inv_time: rose at (%0d,%0d) want (3,900)", edge_tai, edge_cyc); end
      measure_high(w);
    end
  endtask

  task automatic test_abort_mid_pulse();
    logic seen;
    exp_t e;
    // Asynchronous reset in the middle of a pulse
    set_time(40'd30, 28'd0);
    send(40'd30, 28'd500, 1'b1);
    send(40'd30, 28'd2000, 1'b1);
    wait_rise(4000, seen);
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL rst_rise: pulse_o never rose, want rise at (30,3000)");
    end else begin
      e = pop_exp();
      n_tests++;
      if ({edge_tai, edge_cyc} !== {e.tai, e.cyc})
        begin n_fail++; $display("FAIL rst_time: rose at (%0d,%0d) want (%0d,%0d)", edge_tai, edge_cyc, e.tai, e.cyc); end
    end
    repeat (40) tick();
    rst_n_i = 1'b0;
    #1;
    n_tests++;
    if (pulse_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_pulse: got %b want 0", pulse_o); end
    n_tests++;
    if (fifo_count_o !== 5'd0) begin n_fail++; $display("FAIL rst_async_count: got %0d want 0", fifo_count_o); end
    sb.delete();
    repeat (2) tick();
    rst_n_i = 1'b1;
    tick();

    // Synchronous flush through enable_i in the middle of a pulse
    set_time(40'd31, 28'd0);
    send(40'd31, 28'd500, 1'b1);
    send(40'd31, 28'd2000, 1'b1);
    wait_rise(4000, seen);
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL en_rise: pulse_o never rose, want rise at (31,3000)");
    end else begin
      e = pop_exp();
      n_tests++;
      if ({edge_tai, edge_cyc} !== {e.tai, e.cyc})
        begin n_fail++; $display("FAIL en_time: rose at (%0d,%0d) want (%0d,%0d)", edge_tai, edge_cyc, e.tai, e.cyc); end
    end
    repeat (40) tick();
    enable_i   = 1'b0;
    ts_valid_i = 1'b1;
    #1;
    n_tests++;
    if (ts_ready_o !== 1'b0) begin n_fail++; $display("FAIL en_ready: got %b want 0 while disabled", ts_ready_o); end
    n_tests++;
    if (pulse_o !== 1'b1) begin n_fail++; $display("FAIL en_hold: pulse_o %b want 1 before the next edge", pulse_o); end
    tick();
    n_tests++;
    if (pulse_o !== 1'b0) begin n_fail++; $display("FAIL en_pulse: got %b want 0 after edge", pulse_o); end
    n_tests++;
    if (fifo_count_o !== 5'd0) begin n_fail++; $display("FAIL en_count: got %0d want 0", fifo_count_o); end
    tick();
    n_tests++;
    if (overflow_o !== 1'b0 || missed_o !== 1'b0)
      begin n_fail++; $display("FAIL en_strobes: overflow=%b missed=%b want 0 0", overflow_o, missed_o); end
    ts_valid_i = 1'b0;
    enable_i   = 1'b1;
    sb.delete();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_late();
    test_full();
    test_time_invalid();
    test_abort_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within 1 ms");
    $fatal(1, "watchdog");
  end

endmodule
